// File: rtl/shooter_pkg.sv
// Shared game definitions: lane count, BCD digit width and resolver FSM states.
package shooter_pkg;

  localparam int LANES      = 16;
  localparam int BCD_W      = 4;
  localparam int BCD_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCAN     = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit packed BCD counter: +1 with decimal carry, saturating at 9999,
// synchronous clear taking priority over increment.
module bcd_score_counter
  import shooter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  // Next value: clear, else ripple a decimal carry through the digits unless saturated.
  always_comb begin
    logic             carry;
    logic [BCD_W-1:0] dig;
    value_d = value_q;
    carry   = 1'b0;
    dig     = '0;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != 16'h9999)) begin
      carry = 1'b1;
      for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
        dig = value_q[i*BCD_W +: BCD_W];
        if (carry) begin
          if (dig == BCD_W'(9)) begin
            dig = '0;
          end else begin
            dig   = dig + BCD_W'(1);
            carry = 1'b0;
          end
        end
        value_d[i*BCD_W +: BCD_W] = dig;
      end
    end
  end

  // Score register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/shot_resolver.sv
// Shot resolver: latches the lane hit mask on fire, scans one lane per cycle
// for live enemies, pulses kills, scores them in BCD, then locks out fire.
module shot_resolver #(
  parameter int LANES           = shooter_pkg::LANES,
  parameter int COOLDOWN_CYCLES = 12_500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fire,
  input  logic [LANES-1:0] angles_hit,
  input  logic [LANES-1:0] enemy_alive,
  input  logic             score_clear,
  output logic [LANES-1:0] kill,
  output logic [15:0]      score,
  output logic             ready,
  output logic             shot_done
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W = $clog2(COOLDOWN_CYCLES + 1);

  shooter_pkg::state_t state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LANES-1:0]    hit_q, hit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                inc;

  // Next-state and output decode for IDLE -> SCAN -> COOLDOWN.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    cnt_d     = cnt_q;
    kill      = '0;
    inc       = 1'b0;
    ready     = 1'b0;
    shot_done = 1'b0;
    case (state_q)
      shooter_pkg::ST_IDLE: begin
        ready = 1'b1;
        if (fire) begin
          hit_d   = angles_hit;
          idx_d   = '0;
          state_d = shooter_pkg::ST_SCAN;
        end
      end
      shooter_pkg::ST_SCAN: begin
        if (hit_q[idx_q] && enemy_alive[idx_q]) begin
          kill[idx_q] = 1'b1;
          inc         = 1'b1;
        end
        if (idx_q == IDX_W'(LANES - 1)) begin
          shot_done = 1'b1;
          cnt_d     = CNT_W'(COOLDOWN_CYCLES - 1);
          state_d   = shooter_pkg::ST_COOLDOWN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      shooter_pkg::ST_COOLDOWN: begin
        if (cnt_q == '0) state_d = shooter_pkg::ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = shooter_pkg::ST_IDLE;
    endcase
  end

  // FSM, lane index, latched hit mask and cooldown counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= shooter_pkg::ST_IDLE;
      idx_q   <= '0;
      hit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
    end
  end

  bcd_score_counter u_score (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .clr   (score_clear),
    .value (score)
  );

endmodule

// File: doc/shot_resolver.md
SHOT_RESOLVER -- requirements
Module: shot_resolver

Interface
REQ-001 SHALL have parameter LANES, default 16, giving the number of angular lanes, one per 4-bit angle code.
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 12_500_000 (0.5 s at 25 MHz), giving the post-scan lockout length; legal range is 1 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port fire, input, 1 bit: single-cycle shot request from the debounced fire button.
REQ-006 SHALL have port angles_hit, input, LANES bits: lane hit mask from the angle-hit generator; bit i set means lane i is covered.
REQ-007 SHALL have port enemy_alive, input, LANES bits: live-enemy mask from the enemy manager.
REQ-008 SHALL have port score_clear, input, 1 bit: synchronous clear of the score, used on game restart.
REQ-009 SHALL have port kill, output, LANES bits: one-cycle kill pulse mask, at most one bit set per cycle.
REQ-010 SHALL have port score, output, 16 bits: 4-digit packed BCD score, digit 0 in bits [3:0].
REQ-011 SHALL have port ready, output, 1 bit: high only in IDLE, meaning a fire request will be accepted.
REQ-012 SHALL have port shot_done, output, 1 bit: one-cycle pulse on the last SCAN cycle.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SCAN, COOLDOWN.
REQ-014 IDLE with fire=1 SHALL latch angles_hit into hit_reg, clear lane index idx to 0, and enter SCAN; fire is accepted only on that edge.
REQ-015 fire SHALL be ignored, and not queued, in SCAN and COOLDOWN.
REQ-016 SCAN SHALL examine one lane per cycle in ascending order: lane idx is examined idx+1 cycles after the accepting edge.
REQ-017 In SCAN, if hit_reg[idx] and enemy_alive[idx] are both set (enemy_alive sampled live that cycle), kill[idx] SHALL be 1 for that cycle and score SHALL increment by 1 at the following edge.
REQ-018 kill SHALL be 0 in all other cycles and all other bits.
REQ-019 At idx==LANES-1, shot_done SHALL pulse and the FSM SHALL enter COOLDOWN, loading the counter with COOLDOWN_CYCLES-1.
REQ-020 COOLDOWN SHALL decrement the counter each cycle and return to IDLE on the cycle the counter is 0.
REQ-021 Score SHALL count in BCD with decimal carry across digits, e.g. 0x0099 becomes 0x0100.
REQ-022 Score SHALL saturate at 0x9999 and never wrap.
REQ-023 score_clear SHALL set score to 0x0000 at the next edge, take priority over a simultaneous increment, and leave the FSM unaffected.
REQ-024 Changes to angles_hit after the accepting edge SHALL have no effect on the shot in progress.
REQ-025 The counter width SHALL be $clog2(COOLDOWN_CYCLES+1).

Reset
REQ-026 Asserting rst SHALL immediately put the FSM in IDLE and set idx, hit_reg, counter, kill, score and shot_done to 0; ready SHALL read 1.
REQ-027 rst asserted mid-SCAN or mid-COOLDOWN SHALL abort the shot, emit no further kills, and not restore score.

Structure
REQ-028 FSM state encoding, LANES and the BCD digit width SHALL be defined in the shared game package, shooter_pkg.
REQ-029 The BCD increment-with-saturation logic SHALL be a sub-module named bcd_score_counter, with ports clk, rst, inc, clr and value[15:0].

Verification
REQ-030 fire with angles_hit=0x001C and enemy_alive=0x0014 SHALL produce kill=0x0004 at cycle 3, kill=0x0010 at cycle 5, shot_done at cycle 16, and a final score of 0x0002.
REQ-031 A second fire at cycles 5 and 20 (COOLDOWN_CYCLES=8) SHALL produce no new shot; ready SHALL rise at cycle 25, and a fire at cycle 25 SHALL be accepted.
REQ-032 With score preset to 0x0999 and one kill, score SHALL read 0x1000; with score 0x9999 and angles_hit and enemy_alive both 0xFFFF, score SHALL stay 0x9999 while 16 kill pulses still occur.
REQ-033 score_clear asserted in the same cycle as a kill SHALL give score=0x0000 at the next edge.
REQ-034 rst asserted at cycle 7 of a scan with all lanes live SHALL stop kills immediately, set score=0 and ready=1, and the next fire SHALL rescan from lane 0.
REQ-035 angles_hit toggled from 0x0001 to 0x8000 on the cycle after fire SHALL give kill[0] only, with kill[15] never asserted.
